csa_accum: RTL and testbench
============================

Name: csa_accum

Overview:
- Streaming accumulator directly downstream of the 3:2 carry-save compressor stage.
- Accumulates a packet of DW-bit unsigned words in redundant sum/carry form, one word per cycle, with no carry propagation in the accumulate path.
- On the packet's last word, it resolves the redundant pair into a binary result with a multi-cycle sliced carry-propagate adder.
- It then presents the result on a valid/ready output.

Parameters:
- DW, 16, input word width.
- AW, 32, accumulator/result width. Must satisfy AW >= DW. Result is mod 2^AW.
- SW, 8, carry-propagate slice width per resolve cycle. Must satisfy AW % SW == 0. NS = AW/SW.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  DW  unsigned word, zero-extended to AW.
- in_last  input  1  qualifies the accepted word as the last of its packet.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  AW  resolved packet sum mod 2^AW.

Behaviour:
- Reset: one clock, synchronous, active-high. Reset values:
  - state=ACC; s_reg=0, c_reg=0, res_reg=0, slice index=0, cin=0.
  - out_valid=0, out_data=0, in_ready=1 in the first cycle after reset.
- Handshakes:
  - Accept occurs when in_valid & in_ready. Output transfers when out_valid & out_ready.
  - out_data stays stable while out_valid=1 and out_ready=0.
- State ACC:
  - in_ready=1, out_valid=0.
  - On accept: s_reg <= s_reg ^ c_reg ^ ext(in_data).
  - On accept: c_reg <= majority(s_reg, c_reg, ext(in_data)) shifted left 1, with the bit shifted out of the MSB discarded (mod 2^AW).
  - Accept with in_last=1: go to RES with idx=0, cin=0.
  - Cycles with in_valid=0 hold all state.
- State RES:
  - in_ready=0, out_valid=0.
  - Each cycle: {cout, sum} = s_reg[idx*SW +: SW] + c_reg[idx*SW +: SW] + cin.
  - res_reg slice idx <= sum; cin <= cout; idx++.
  - After slice NS-1: go to OUT. The final cout is discarded.
- State OUT:
  - in_ready=0, out_valid=1, out_data=res_reg.
  - On transfer: s_reg, c_reg, idx, cin <= 0; go to ACC.
  - in_ready returns to 1 the cycle after the transfer.
- Latency: with the last word accepted on edge k, out_valid=1 in the cycle following edge k+NS (NS cycles). Throughput is one word per cycle within a packet.
- Single-word packet (in_last on first word) is legal and gives result = in_data.
- A packet with in_last and in_valid gaps between words is legal.
- Overflow: the sum wraps mod 2^AW silently. There is no flag.
- rst asserted in any state (mid-RES or OUT included) aborts the packet and restores the reset values next cycle. No partial result is emitted.
- out_data is driven only by res_reg; no combinational path from in_data to out_data.
- No combinational path from out_ready to in_ready.

Decomposition:
- Shared package holds:
  - localparam NS = AW/SW and index width $clog2(NS) (minimum 1).
  - typedef enum state_t {ACC, RES, OUT}.
  - Elaboration-time assertion helpers for AW >= DW and AW % SW == 0.
- Accumulate path instantiates the team's existing csa32 compressor with DW=AW.
- One new sub-module: cpa_slice, an SW-bit adder with carry in/out, instantiated once and muxed by idx.

Test Plan:
- DW=16, AW=32, SW=8, single word 0x1234 with in_last accepted on edge k:
  - out_valid rises in the cycle after edge k+4; out_data=0x00001234.
  - in_ready=0 from edge k until the transfer.
- Three words 0xFFFF, 0xFFFF, 0xFFFF (last on third), out_ready=1 -> out_data=0x0002FFFD, one transfer.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid.
  - out_data stays stable and out_valid stays 1; in_ready stays 0.
  - Transfer on the 4th cycle; in_ready=1 on the next cycle.
- Wrap, with DW=16, AW=16, SW=4: words 0xFFFF, 0x0001 -> out_data=0x0000 after 4 resolve cycles.
- Reset mid-RES: assert rst for 1 cycle during idx=2.
  - out_valid never rises; in_ready=1 the cycle after reset.
  - The next packet, single word 0x0005, yields 0x00000005.
- Back-to-back packets with in_valid gaps: {1,2,3 last} then {10 last}.
  - Outputs are 6 then 10, in order.
  - No word is accepted while in RES or OUT.

Source files
------------

// File: rtl/csa_accum_pkg.sv
// Shared types and elaboration helpers for the carry-save packet accumulator.
// Width arithmetic lives here so the top and any future wrappers agree on it.
package csa_accum_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_AW = 32;
    localparam int DEF_SW = 8;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        RES = 2'd1,
        OUT = 2'd2
    } state_t;

    // Number of carry-propagate slices needed to resolve an AW-bit pair.
    function automatic int ns_of(input int aw, input int sw);
        return aw / sw;
    endfunction

    // Slice index width; never narrower than one bit so NS=1 still builds.
    function automatic int idx_w_of(input int ns);
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

    function automatic bit width_ok(input int dw, input int aw);
        return (aw >= dw) && (dw > 0);
    endfunction

    function automatic bit slice_ok(input int aw, input int sw);
        return (sw > 0) && (sw <= aw) && ((aw % sw) == 0);
    endfunction

endpackage

// File: rtl/csa32.sv
// 3:2 carry-save compressor: three operands in, redundant sum/carry out.
// The carry vector is pre-shifted; the bit leaving the MSB is dropped (mod 2^DW).
module csa32 #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] c_i,
    output logic [DW-1:0] sum_o,
    output logic [DW-1:0] carry_o
);

    logic [DW-1:0] maj;

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign carry_o = maj << 1;

endmodule

// File: rtl/csa_accum_cpa_slice.sv
// SW-bit ripple adder with carry in/out; one slice of the multi-cycle resolve.
module cpa_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          cin_i,
    output logic [SW-1:0] sum_o,
    output logic          cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, cin_i};

endmodule

// File: rtl/csa_accum.sv
// Streaming packet accumulator: carry-save accumulate, then a sliced
// multi-cycle carry-propagate resolve, then a valid/ready result.
module csa_accum
    import csa_accum_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int SW = DEF_SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic [1:0]    dbg_state_o
);

    localparam int NS = ns_of(AW, SW);
    localparam int IW = idx_w_of(NS);

    generate
        if (!width_ok(DW, AW)) begin : g_bad_aw
            $error("csa_accum: AW must be >= DW");
        end
        if (!slice_ok(AW, SW)) begin : g_bad_sw
            $error("csa_accum: AW must be a multiple of SW");
        end
    endgenerate

    // Handshake: a word moves when in_valid & in_ready, the result moves when
    // out_valid & out_ready. Both readies/valids are pure decodes of state_q,
    // so out_ready never reaches in_ready combinationally.
    state_t        state_q, state_d;
    logic [AW-1:0] s_q, s_d;
    logic [AW-1:0] c_q, c_d;
    logic [AW-1:0] res_q, res_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cin_q, cin_d;

    logic [AW-1:0] word_ext;
    logic [AW-1:0] csa_sum;
    logic [AW-1:0] csa_carry;
    logic [SW-1:0] sl_s;
    logic [SW-1:0] sl_c;
    logic [SW-1:0] sl_sum;
    logic          sl_cout;
    logic          accept;
    logic          xfer;

    assign word_ext    = AW'(in_data);
    assign in_ready    = (state_q == ACC);
    assign out_valid   = (state_q == OUT);
    assign out_data    = res_q;
    assign dbg_state_o = state_q;
    assign accept      = in_valid & in_ready;
    assign xfer        = out_valid & out_ready;

    csa32 #(
        .DW (AW)
    ) u_csa (
        .a_i     (s_q),
        .b_i     (c_q),
        .c_i     (word_ext),
        .sum_o   (csa_sum),
        .carry_o (csa_carry)
    );

    // One shared slice adder; the operands are picked by the slice index.
    assign sl_s = s_q[idx_q*SW +: SW];
    assign sl_c = c_q[idx_q*SW +: SW];

    cpa_slice #(
        .SW (SW)
    ) u_cpa (
        .a_i    (sl_s),
        .b_i    (sl_c),
        .cin_i  (cin_q),
        .sum_o  (sl_sum),
        .cout_o (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        res_d   = res_q;
        idx_d   = idx_q;
        cin_d   = cin_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    s_d = csa_sum;
                    c_d = csa_carry;
                    if (in_last) begin
                        state_d = RES;
                        idx_d   = '0;
                        cin_d   = 1'b0;
                    end
                end
            end
            RES: begin
                res_d[idx_q*SW +: SW] = sl_sum;
                cin_d = sl_cout;
                idx_d = idx_q + IW'(1);
                // Carry out of the top slice is the mod-2^AW overflow; dropped.
                if (idx_q == IW'(NS - 1)) begin
                    state_d = OUT;
                    idx_d   = '0;
                end
            end
            OUT: begin
                if (xfer) begin
                    state_d = ACC;
                    s_d     = '0;
                    c_d     = '0;
                    idx_d   = '0;
                    cin_d   = 1'b0;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            s_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            cin_q   <= cin_d;
        end
    end

endmodule

// File: tb/tb_csa_accum.sv
// Bench for csa_accum: a 16/32/8 instance and a 16/16/4 instance on one clock,
// expected sums computed as plain integer addition of each packet's words.
module tb_csa_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
    logic [15:0] a_in_data;
    logic [31:0] a_out_data;
    logic [1:0]  a_dbg;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
    logic [15:0] b_in_data;
    logic [15:0] b_out_data;
    logic [1:0]  b_dbg;

    csa_accum #(.DW(16), .AW(32), .SW(8)) u_a (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .in_data     (a_in_data),
        .in_last     (a_in_last),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_data    (a_out_data),
        .dbg_state_o (a_dbg)
    );

    csa_accum #(.DW(16), .AW(16), .SW(4)) u_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_data     (b_in_data),
        .in_last     (b_in_last),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_data    (b_out_data),
        .dbg_state_o (b_dbg)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [15:0] pkt_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v, input logic [15:0] d, input logic l);
        if (sel) begin
            b_in_valid = v; b_in_data = d; b_in_last = l;
        end else begin
            a_in_valid = v; a_in_data = d; a_in_last = l;
        end
    endtask

    task automatic set_ready(input bit sel, input logic r);
        if (sel) b_out_ready = r;
        else     a_out_ready = r;
    endtask

    function automatic logic obs_in_ready(input bit sel);
        return sel ? b_in_ready : a_in_ready;
    endfunction

    function automatic logic obs_valid(input bit sel);
        return sel ? b_out_valid : a_out_valid;
    endfunction

    function automatic logic [31:0] obs_data(input bit sel);
        return sel ? {16'h0, b_out_data} : a_out_data;
    endfunction

    // Sends pkt_q as one packet with random idle gaps; queues its modular sum.
    task automatic send_packet(input bit sel, input int aw, input int max_gap);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < pkt_q.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            check("in_ready before word", 32'(obs_in_ready(sel)), 32'd1);
            drive(sel, 1'b1, pkt_q[i], (i == pkt_q.size() - 1));
            tick();
            drive(sel, 1'b0, 16'h0, 1'b0);
            acc = acc + 64'(pkt_q[i]);
        end
        exp_q.push_back(32'(acc & ((64'd1 << aw) - 64'd1)));
    endtask

    // Waits for the result, holds it for bp cycles, then takes it.
    // With junk set, in_valid stays high with garbage while the block is busy.
    task automatic take_result(input bit sel, input string tag, input int bp, input bit junk);
        int          lat;
        logic [31:0] exp;
        lat = 0;
        if (junk) drive(sel, 1'b1, 16'h7777, 1'b0);
        while (!obs_valid(sel) && lat < 30) begin
            check({tag, " in_ready busy"}, 32'(obs_in_ready(sel)), 32'd0);
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, 32'd4);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, " out_data"}, obs_data(sel), exp);
        for (int i = 0; i < bp; i++) begin
            check({tag, " hold out_valid"}, 32'(obs_valid(sel)), 32'd1);
            check({tag, " hold out_data"}, obs_data(sel), exp);
            check({tag, " hold in_ready"}, 32'(obs_in_ready(sel)), 32'd0);
            tick();
        end
        set_ready(sel, 1'b1);
        tick();
        set_ready(sel, 1'b0);
        if (junk) drive(sel, 1'b0, 16'h0, 1'b0);
        check({tag, " out_valid after xfer"}, 32'(obs_valid(sel)), 32'd0);
        check({tag, " in_ready after xfer"}, 32'(obs_in_ready(sel)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_valid;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst a in_ready", 32'(a_in_ready), 32'd1);
        check("rst a out_valid", 32'(a_out_valid), 32'd0);
        check("rst a out_data", a_out_data, 32'd0);
        check("rst a state", 32'(a_dbg), 32'd0);
        check("rst b out_valid", 32'(b_out_valid), 32'd0);
        check("rst b out_data", 32'(b_out_data), 32'd0);

        // Single word
        pkt_q = '{16'h1234};
        send_packet(1'b0, 32, 0);
        take_result(1'b0, "single 0x1234", 0, 1'b0);

        // Three 0xFFFF words
        pkt_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
        send_packet(1'b0, 32, 0);
        check("three ffff model", exp_q[0], 32'h0002FFFD);
        take_result(1'b0, "three ffff", 0, 1'b0);

        // Backpressure for three cycles
        pkt_q = '{16'(($urandom)), 16'(($urandom))};
        send_packet(1'b0, 32, 1);
        take_result(1'b0, "backpressure", 3, 1'b0);

        // Wrap on the 16-bit instance
        pkt_q = '{16'hFFFF, 16'h0001};
        send_packet(1'b1, 16, 0);
        check("wrap model", exp_q[0], 32'h0000);
        take_result(1'b1, "wrap aw16", 1, 1'b0);

        // Reset while resolving slice 2
        drive(1'b0, 1'b1, 16'h0042, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        tick();
        check("midres state", 32'(a_dbg), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midres in_ready", 32'(a_in_ready), 32'd1);
        check("midres out_valid", 32'(a_out_valid), 32'd0);
        check("midres out_data", a_out_data, 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_out_valid) seen_valid++;
            tick();
        end
        check("midres no output", seen_valid, 32'd0);
        pkt_q = '{16'h0005};
        send_packet(1'b0, 32, 0);
        take_result(1'b0, "after reset", 0, 1'b0);

        // Back-to-back packets with gaps and junk offered while busy
        pkt_q = '{16'd1, 16'd2, 16'd3};
        send_packet(1'b0, 32, 2);
        check("b2b first model", exp_q[0], 32'd6);
        take_result(1'b0, "b2b 6", 0, 1'b1);
        pkt_q = '{16'd10};
        send_packet(1'b0, 32, 2);
        take_result(1'b0, "b2b 10", 0, 1'b1);

        // Random packets on both instances
        for (int p = 0; p < 8; p++) begin
            bit sel;
            sel = (p % 4 == 3);
            pkt_q.delete();
            repeat ($urandom_range(1, 6)) pkt_q.push_back(16'($urandom));
            send_packet(sel, sel ? 16 : 32, 2);
            take_result(sel, sel ? "rand b" : "rand a", $urandom_range(0, 3), p[0]);
        end

        check("expect queue drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
